irst_scan_ctrl: RTL and testbench

- Sequencer that, on request, freezes the mips_16 core pipeline and walks every architectural register through a dedicated register-file read port.
- Compacts the register contents into a 16-bit rotate-XOR signature and reports completion on irst_reg_data / irst_done.
- Sits between mips_16_core_top (stall handshake) and register_file (scan read port), and feeds the fault-injection test flow.

---
 rtl/irst_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_irst_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irst_scan_ctrl.sv
// ----------------------------------------------------------------------------
// irst_scan_ctrl: freezes the core, scans R0..R7 into a rotate-XOR signature. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irst_scan_ctrl #(
  parameter int              NUM_REGS  = 8,
  parameter int              ADDR_W    = 3,
  parameter int              DATA_W    = 16,
  parameter logic [DATA_W-1:0] SEED    = 16'hACE1,
  parameter int              DRAIN_CYC = 2,
  parameter int              TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              stall_req,
  input  logic              stall_ack,
  output logic              scan_rd_en,
  output logic [ADDR_W-1:0] scan_addr,
  input  logic [DATA_W-1:0] scan_rd_data,
  output logic [DATA_W-1:0] irst_reg_data,
  output logic              irst_done,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + DRAIN_CYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_DRAIN = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   sig_q;
  logic [DATA_W-1:0]   sig_d;
  logic [DATA_W-1:0]   reg_data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                stall_req_q;
  logic                rd_en_q;
  logic                done_q;
  logic                busy_q;
  logic                err_q;

  assign sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ scan_rd_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sig_q       <= SEED;
      reg_data_q  <= SEED;
      addr_q      <= '0;
      stall_req_q <= 1'b0;
      rd_en_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_REQ;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            stall_req_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_REQ: begin
          if (stall_ack) begin
            state_q <= S_DRAIN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q     <= S_ERR;
            err_q       <= 1'b1;
            stall_req_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!stall_ack) begin
            state_q     <= S_ERR;
            err_q       <= 1'b1;
            stall_req_q <= 1'b0;
          end else if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
            state_q <= S_SCAN;
            addr_q  <= '0;
            sig_q   <= SEED;
            rd_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SCAN: begin
          // Losing the freeze mid-scan makes the partial signature meaningless.
          if (!stall_ack) begin
            state_q     <= S_ERR;
            err_q       <= 1'b1;
            stall_req_q <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
          end else begin
            sig_q <= sig_d;
            if (addr_q == ADDR_W'(NUM_REGS - 1)) begin
              state_q     <= S_DONE;
              addr_q      <= '0;
              rd_en_q     <= 1'b0;
              stall_req_q <= 1'b0;
              reg_data_q  <= sig_d;
              done_q      <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_ERR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          stall_req_q <= 1'b0;
          rd_en_q     <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign stall_req     = stall_req_q;
  assign scan_rd_en    = rd_en_q;
  assign scan_addr     = addr_q;
  assign irst_reg_data = reg_data_q;
  assign irst_done     = done_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_irst_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irst_scan_ctrl: directed self-checking bench for irst_scan_ctrl. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_irst_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stall_ack = 1'b0;
  logic        stall_req;
  logic        scan_rd_en;
  logic [2:0]  scan_addr;
  logic [15:0] scan_rd_data;
  logic [15:0] irst_reg_data;
  logic        irst_done;
  logic        busy;
  logic        err;

  logic [15:0] regs [8];
  int total = 0;
  int bad   = 0;

  assign scan_rd_data = regs[scan_addr];

  always #5 clk = ~clk;

  irst_scan_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall_req    (stall_req),
    .stall_ack    (stall_ack),
    .scan_rd_en   (scan_rd_en),
    .scan_addr    (scan_addr),
    .scan_rd_data (scan_rd_data),
    .irst_reg_data(irst_reg_data),
    .irst_done    (irst_done),
    .busy         (busy),
    .err          (err)
  );

  // Observation k happens at the negedge after edge E(k), E0 being the start edge.
  // Drives applied at observation k take effect at edge E(k+1).
  // snap = {done, busy, stall_req, rd_en, err, addr[2:0], reg_data[15:0]}
  task automatic run_scan(input int ncyc, input int ack_rise_k, input int ack_drop_k,
                          input int pulse_a, input int pulse_b, input int rst_k,
                          input int snap_k,
                          output int done_k, output int ndone, output int sreq_n,
                          output int rden_n, output int addr_bad, output int err_k,
                          output logic [23:0] snap);
    done_k = -1; ndone = 0; sreq_n = 0; rden_n = 0; addr_bad = 0; err_k = -1;
    snap = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (irst_done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (stall_req) sreq_n++;
      if (scan_rd_en) begin
        if (scan_addr !== rden_n[2:0]) addr_bad++;
        rden_n++;
      end
      if (err && err_k < 0) err_k = k;
      if (k == snap_k)
        snap = {irst_done, busy, stall_req, scan_rd_en, err, scan_addr, irst_reg_data};
      start = (k == pulse_a || k == pulse_b);
      if (k == ack_rise_k) stall_ack = 1'b1;
      if (k == ack_drop_k) stall_ack = 1'b0;
      rst = (k == rst_k) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    if ({stall_req, scan_rd_en, irst_done, busy, err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {stall_req, scan_rd_en, irst_done, busy, err});
    end
    total++;
    if (scan_addr !== 3'd0) begin
      bad++; $display("FAIL reset_addr got=%0d want=0", scan_addr);
    end
    total++;
    if (irst_reg_data !== 16'hACE1) begin
      bad++; $display("FAIL reset_sig got=%h want=ace1", irst_reg_data);
    end
    total++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_regs();
    int dk, nd, sr, rd, ab, ek;
    logic [23:0] sn;
    foreach (regs[i]) regs[i] = 16'h0000;
    stall_ack = 1'b1;
    run_scan(20, -1, -1, -1, -1, -1, 11, dk, nd, sr, rd, ab, ek, sn);
    if (dk !== 11) begin bad++; $display("FAIL zero_done_lat got=%0d want=11", dk); end
    total++;
    if (nd !== 1) begin bad++; $display("FAIL zero_done_cnt got=%0d want=1", nd); end
    total++;
    if (sr !== 11) begin bad++; $display("FAIL zero_sreq_cycles got=%0d want=11", sr); end
    total++;
    if (sn[23:16] !== 8'b11000000) begin
      bad++; $display("FAIL zero_done_cycle_ctrl got=%b want=11000000", sn[23:16]);
    end
    total++;
    if (sn[15:0] !== 16'hE1AC) begin
      bad++; $display("FAIL zero_sig_at_done got=%h want=e1ac", sn[15:0]);
    end
    total++;
    if (irst_reg_data !== 16'hE1AC) begin
      bad++; $display("FAIL zero_sig_hold got=%h want=e1ac", irst_reg_data);
    end
    total++;
  endtask

  task automatic test_ramp();
    int dk, nd, sr, rd, ab, ek;
    logic [23:0] sn;
    foreach (regs[i]) regs[i] = 16'(i);
    stall_ack = 1'b1;
    run_scan(20, -1, -1, -1, -1, -1, 0, dk, nd, sr, rd, ab, ek, sn);
    if (irst_reg_data !== 16'hE1A3) begin
      bad++; $display("FAIL ramp_sig got=%h want=e1a3", irst_reg_data);
    end
    total++;
    if (rd !== 8) begin bad++; $display("FAIL ramp_rden_cycles got=%0d want=8", rd); end
    total++;
    if (ab !== 0) begin bad++; $display("FAIL ramp_addr_seq got=%0d bad_addrs want=0", ab); end
    total++;
    if (dk !== 11) begin bad++; $display("FAIL ramp_done_lat got=%0d want=11", dk); end
    total++;
  endtask

  task automatic test_timeout();
    int dk, nd, sr, rd, ab, ek;
    logic [23:0] sn;
    stall_ack = 1'b0;
    run_scan(24, -1, -1, -1, -1, -1, 20, dk, nd, sr, rd, ab, ek, sn);
    if (ek !== 16) begin bad++; $display("FAIL timeout_err_at got=%0d want=16", ek); end
    total++;
    if (sr !== 16) begin bad++; $display("FAIL timeout_sreq_cycles got=%0d want=16", sr); end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL timeout_no_done got=%0d want=0", nd); end
    total++;
    if (sn[23:19] !== 5'b00001) begin
      bad++; $display("FAIL timeout_idle_ctrl got=%b want=00001", sn[23:19]);
    end
    total++;
    if (irst_reg_data !== 16'hE1A3) begin
      bad++; $display("FAIL timeout_sig_kept got=%h want=e1a3", irst_reg_data);
    end
    total++;
    stall_ack = 1'b1;
    run_scan(20, -1, -1, -1, -1, -1, 0, dk, nd, sr, rd, ab, ek, sn);
    if (sn[19] !== 1'b0) begin bad++; $display("FAIL err_clear_on_start got=%b want=0", sn[19]); end
    total++;
    if (dk !== 11 || irst_reg_data !== 16'hE1A3) begin
      bad++; $display("FAIL err_recover got=lat%0d/%h want=lat11/e1a3", dk, irst_reg_data);
    end
    total++;
  endtask

  task automatic test_ack_delay();
    int dk, nd, sr, rd, ab, ek;
    logic [23:0] sn;
    foreach (regs[i]) regs[i] = 16'h0000;
    stall_ack = 1'b0;
    run_scan(25, 5, -1, -1, -1, -1, 0, dk, nd, sr, rd, ab, ek, sn);
    if (dk !== 16) begin bad++; $display("FAIL ackdly_done_lat got=%0d want=16", dk); end
    total++;
    if (irst_reg_data !== 16'hE1AC || ek !== -1) begin
      bad++; $display("FAIL ackdly_sig got=%h err_at=%0d want=e1ac/-1", irst_reg_data, ek);
    end
    total++;
  endtask

  task automatic test_back_to_back();
    int dk, nd, sr, rd, ab, ek;
    logic [23:0] sn;
    foreach (regs[i]) regs[i] = 16'(i);
    stall_ack = 1'b1;
    run_scan(30, -1, -1, 5, 11, -1, 29, dk, nd, sr, rd, ab, ek, sn);
    if (nd !== 1) begin bad++; $display("FAIL b2b_done_cnt got=%0d want=1", nd); end
    total++;
    if (sr !== 11 || sn[22] !== 1'b0) begin
      bad++; $display("FAIL b2b_no_rescan got=sreq%0d busy%b want=sreq11 busy0", sr, sn[22]);
    end
    total++;
    if (irst_reg_data !== 16'hE1A3) begin
      bad++; $display("FAIL b2b_sig got=%h want=e1a3", irst_reg_data);
    end
    total++;
  endtask

  task automatic test_ack_drop();
    int dk, nd, sr, rd, ab, ek;
    logic [23:0] sn;
    foreach (regs[i]) regs[i] = 16'h0000;
    stall_ack = 1'b1;
    run_scan(20, -1, 6, -1, -1, -1, 0, dk, nd, sr, rd, ab, ek, sn);
    if (ek !== 7 || nd !== 0) begin
      bad++; $display("FAIL ackdrop got=err_at%0d done%0d want=err_at7 done0", ek, nd);
    end
    total++;
    if (irst_reg_data !== 16'hE1A3) begin
      bad++; $display("FAIL ackdrop_sig_kept got=%h want=e1a3", irst_reg_data);
    end
    total++;
    stall_ack = 1'b1;
  endtask

  task automatic test_mid_reset();
    int dk, nd, sr, rd, ab, ek;
    logic [23:0] sn;
    foreach (regs[i]) regs[i] = 16'(i);
    stall_ack = 1'b1;
    run_scan(20, -1, -1, -1, -1, 5, 6, dk, nd, sr, rd, ab, ek, sn);
    if (sn !== {8'b00000000, 16'hACE1}) begin
      bad++; $display("FAIL midrst_outputs got=%h want=00ace1", sn);
    end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", nd); end
    total++;
    run_scan(20, -1, -1, -1, -1, -1, 0, dk, nd, sr, rd, ab, ek, sn);
    if (dk !== 11 || irst_reg_data !== 16'hE1A3) begin
      bad++; $display("FAIL midrst_recover got=lat%0d/%h want=lat11/e1a3", dk, irst_reg_data);
    end
    total++;
  endtask

  initial begin
    foreach (regs[i]) regs[i] = 16'h0000;
    test_reset();
    test_zero_regs();
    test_ramp();
    test_timeout();
    test_ack_delay();
    test_back_to_back();
    test_ack_drop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
